// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences IDLE/DECODE/EXECUTE/MEM/WB for a small
// MIPS-like subset and emits the per-cycle datapath control strobes.
module multicycle_control_unit #(
  parameter int INSTR_W      = 32,
  parameter int OPC_W        = 6,
  parameter int FUNCT_W      = 6,
  parameter int ALU_OP_W     = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  Instruction_Code,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                imm_signal,
  output logic                alu_en,
  output logic                Reg_Write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                done,
  output logic                illegal_instr,
  output logic                mem_error
);

  localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [OPC_W-1:0] OPC_RTYPE = '0;
  localparam logic [OPC_W-1:0] OPC_ADDI  = OPC_W'(6'b111111);
  localparam logic [OPC_W-1:0] OPC_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OPC_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OPC_BEQ   = OPC_W'(6'b000100);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLL = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] FN_SRL = FUNCT_W'(6'b000010);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ADDI,
    C_LW,
    C_SW,
    C_BEQ
  } iclass_t;

  state_t               state_q, state_d;
  iclass_t              cls_q, cls_d;
  logic [OPC_W-1:0]     opc_q, opc_d;
  logic [FUNCT_W-1:0]   funct_q, funct_d;
  logic [3:0]           alu_op_q, alu_op_d;
  logic                 imm_q, imm_d;
  logic [CNT_W-1:0]     wait_q, wait_d;

  logic                 dec_valid;
  logic [3:0]           dec_op;
  logic                 dec_imm;
  iclass_t              dec_cls;
  logic                 mem_timeout;
  logic                 instr_unused;

  // Only the opcode and funct fields steer control; the operand fields are
  // consumed by the datapath, so they are not latched here.
  assign instr_unused = ^Instruction_Code;

  always_comb begin
    dec_valid = 1'b1;
    dec_op    = 4'b0000;
    dec_imm   = 1'b0;
    dec_cls   = C_RTYPE;
    case (opc_q)
      OPC_RTYPE: begin
        dec_cls = C_RTYPE;
        case (funct_q)
          FN_ADD:  dec_op = 4'b0010;
          FN_SUB:  dec_op = 4'b0110;
          FN_AND:  dec_op = 4'b0000;
          FN_OR:   dec_op = 4'b0001;
          FN_SLL:  dec_op = 4'b1110;
          FN_SRL:  dec_op = 4'b1100;
          default: dec_valid = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        dec_cls = C_ADDI;
        dec_op  = 4'b0010;
        dec_imm = 1'b1;
      end
      OPC_LW: begin
        dec_cls = C_LW;
        dec_op  = 4'b0010;
        dec_imm = 1'b1;
      end
      OPC_SW: begin
        dec_cls = C_SW;
        dec_op  = 4'b0010;
        dec_imm = 1'b1;
      end
      OPC_BEQ: begin
        dec_cls = C_BEQ;
        dec_op  = 4'b0110;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // The wait counter equals the number of MEM cycles already spent waiting.
  assign mem_timeout = (wait_q == CNT_W'(MEM_WAIT_MAX));

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    opc_d         = opc_q;
    funct_d       = funct_q;
    alu_op_d      = alu_op_q;
    imm_d         = imm_q;
    wait_d        = wait_q;
    instr_ready   = 1'b0;
    alu_en        = 1'b0;
    Reg_Write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    done          = 1'b0;
    illegal_instr = 1'b0;
    mem_error     = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opc_d   = Instruction_Code[INSTR_W-1 -: OPC_W];
          funct_d = Instruction_Code[FUNCT_W-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_valid) begin
          alu_op_d = dec_op;
          imm_d    = dec_imm;
          cls_d    = dec_cls;
          state_d  = S_EXECUTE;
        end else begin
          illegal_instr = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        wait_d = '0;
        case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            branch  = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_timeout) begin
          mem_error = 1'b1;
          wait_d    = '0;
          state_d   = S_IDLE;
        end else begin
          mem_read  = (cls_q == C_LW);
          mem_write = (cls_q == C_SW);
          if (mem_ready) begin
            wait_d = '0;
            if (cls_q == C_LW) begin
              state_d = S_WB;
            end else begin
              done    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end
      S_WB: begin
        Reg_Write = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cls_q    <= C_RTYPE;
      opc_q    <= '0;
      funct_q  <= '0;
      alu_op_q <= 4'b0000;
      imm_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      opc_q    <= opc_d;
      funct_q  <= funct_d;
      alu_op_q <= alu_op_d;
      imm_q    <= imm_d;
      wait_q   <= wait_d;
    end
  end

  assign ALU_op     = ALU_OP_W'(alu_op_q);
  assign imm_signal = imm_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: drivers queue the expected
// retire/abort record, a negedge monitor builds the observed record and compares.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] Instruction_Code;
  logic        instr_ready;
  logic        mem_ready;
  logic [3:0]  ALU_op;
  logic        imm_signal;
  logic        alu_en;
  logic        Reg_Write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        done;
  logic        illegal_instr;
  logic        mem_error;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .Instruction_Code (Instruction_Code),
    .instr_ready      (instr_ready),
    .mem_ready        (mem_ready),
    .ALU_op           (ALU_op),
    .imm_signal       (imm_signal),
    .alu_en           (alu_en),
    .Reg_Write        (Reg_Write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .branch           (branch),
    .done             (done),
    .illegal_instr    (illegal_instr),
    .mem_error        (mem_error)
  );

  // ev: 0 done, 1 illegal, 2 mem_error, 3 reset recovery, 9 overlapping strobes.
  // lat: cycles after the acceptance edge (reset record: OR of the pulses).
  // rd/wr/alu: cycles mem_read/mem_write/alu_en were high up to the event.
  typedef struct {
    string      name;
    int         ev;
    int         lat;
    logic [3:0] op;
    bit         chk_op;
    logic       imm;
    logic       rw;
    logic       br;
    int         rd;
    int         wr;
    int         alu;
    logic       rdy;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit   in_flight = 1'b0;
  bit   rst_seen  = 1'b0;
  bit   rdy_next  = 1'b0;
  int   cyc, rd_cnt, wr_cnt, alu_cnt;

  function automatic rec_t mk(input string name, input int ev, input int lat,
                              input logic [3:0] op, input bit chk_op, input logic imm,
                              input logic rw, input logic br, input int rd,
                              input int wr, input int alu, input logic rdy);
    rec_t r;
    r.name = name; r.ev = ev; r.lat = lat; r.op = op; r.chk_op = chk_op;
    r.imm = imm; r.rw = rw; r.br = br; r.rd = rd; r.wr = wr; r.alu = alu; r.rdy = rdy;
    return r;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'b000000, 20'h0_1234, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc);
    return {opc, 26'h0_00ab_cd};
  endfunction

  task automatic checkOutput(input rec_t act);
    rec_t e;
    bit   ok;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL unexpected_event: got ev=%0d lat=%0d, required no event", act.ev, act.lat);
      return;
    end
    e  = exp_q.pop_front();
    ok = (act.ev == e.ev) && (act.lat == e.lat) && (act.rw === e.rw) && (act.br === e.br) &&
         (act.rd == e.rd) && (act.wr == e.wr) && (act.alu == e.alu) && (act.rdy === e.rdy) &&
         (!e.chk_op || ((act.op === e.op) && (act.imm === e.imm)));
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL %s: got ev=%0d lat=%0d op=%b imm=%b rw=%b br=%b rd=%0d wr=%0d alu=%0d rdy=%b, required ev=%0d lat=%0d op=%b imm=%b rw=%b br=%b rd=%0d wr=%0d alu=%0d rdy=%b",
               e.name, act.ev, act.lat, act.op, act.imm, act.rw, act.br, act.rd, act.wr, act.alu, act.rdy,
               e.ev, e.lat, e.op, e.imm, e.rw, e.br, e.rd, e.wr, e.alu, e.rdy);
    end else begin
      $display("[TB] ok %s", e.name);
    end
  endtask

  // Monitor: samples on the falling edge, tracks each accepted instruction
  // from its acceptance edge and reports a record when it retires or aborts.
  always @(negedge clk) begin
    rec_t act;
    int   n_pulse;
    if (!rst_n) begin
      rst_seen  = 1'b1;
      in_flight = 1'b0;
      rdy_next  = 1'b0;
    end else begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        act = mk("reset", 3, int'(done | illegal_instr | mem_error), ALU_op, 1'b1, imm_signal,
                 Reg_Write, branch, int'(mem_read), int'(mem_write), int'(alu_en), instr_ready);
        checkOutput(act);
      end
      if (rdy_next) begin
        rdy_next = 1'b0;
        n_cmp++;
        if (instr_ready !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL ready_after_event: instr_ready=%b, required 1", instr_ready);
        end
      end
      if (in_flight) begin
        cyc++;
        rd_cnt  += int'(mem_read);
        wr_cnt  += int'(mem_write);
        alu_cnt += int'(alu_en);
        n_pulse = int'(done) + int'(illegal_instr) + int'(mem_error);
        if (n_pulse != 0) begin
          act = mk("event", (n_pulse > 1) ? 9 : (done ? 0 : (illegal_instr ? 1 : 2)), cyc,
                   ALU_op, 1'b1, imm_signal, Reg_Write, branch, rd_cnt, wr_cnt, alu_cnt, instr_ready);
          checkOutput(act);
          in_flight = 1'b0;
          rdy_next  = 1'b1;
        end
      end
      if (instr_valid && instr_ready) begin
        in_flight = 1'b1;
        cyc       = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        alu_cnt   = 0;
      end
    end
  end

  // Issues one instruction: queue its expectation, wait for acceptance, then
  // drive mem_ready on the given cycle (0 = never) until the unit is idle.
  task automatic applyStimulus(input rec_t e, input logic [31:0] code, input int rdy_cyc,
                               input bit noise, input bit hold, input logic [31:0] next_code);
    int g;
    int c;
    exp_q.push_back(e);
    instr_valid      = 1'b1;
    Instruction_Code = code;
    g = 0;
    while (!instr_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!instr_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL %s_accept: instr_ready=%b after %0d cycles, required 1", e.name, instr_ready, g);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (hold) begin
      Instruction_Code = next_code;
    end else begin
      instr_valid      = 1'b0;
      Instruction_Code = $urandom;
    end
    c = 1;
    while (!instr_ready && c < 40) begin
      mem_ready = (c == rdy_cyc) || (noise && c <= 2);
      @(posedge clk); #1;
      c++;
    end
    mem_ready = 1'b0;
    if (!instr_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL %s_finish: instr_ready=%b after %0d cycles, required 1", e.name, instr_ready, c);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    instr_valid      = 1'b0;
    Instruction_Code = '0;
    mem_ready        = 1'b0;
    exp_q.push_back(mk("power_on_reset", 3, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(mk("add", 0, 3, 4'h2, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b100000), 0, 0, 0, '0);
    applyStimulus(mk("sub", 0, 3, 4'h6, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b100010), 0, 0, 0, '0);
    applyStimulus(mk("and", 0, 3, 4'h0, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b100100), 0, 0, 0, '0);
    applyStimulus(mk("or",  0, 3, 4'h1, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b100101), 0, 0, 0, '0);
    applyStimulus(mk("sll", 0, 3, 4'he, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b000000), 0, 0, 0, '0);
    applyStimulus(mk("srl", 0, 3, 4'hc, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b000010), 0, 0, 0, '0);
    applyStimulus(mk("addi", 0, 3, 4'h2, 1, 1, 1, 0, 0, 0, 1, 0), itype(6'b111111), 0, 0, 0, '0);
    // mem_ready is also pulsed in DECODE/EXECUTE, where it must be ignored.
    applyStimulus(mk("lw_wait3", 0, 6, 4'h2, 1, 1, 1, 0, 3, 0, 1, 0), itype(6'b100011), 5, 1, 0, '0);
    applyStimulus(mk("sw_fast", 0, 3, 4'h2, 1, 1, 0, 0, 0, 1, 1, 0), itype(6'b101011), 3, 0, 0, '0);
    applyStimulus(mk("sw_timeout", 2, 18, 4'h2, 1, 1, 0, 0, 0, 15, 1, 0), itype(6'b101011), 0, 0, 0, '0);
    applyStimulus(mk("illegal_opcode", 1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0), itype(6'b010101), 0, 0, 0, '0);
    applyStimulus(mk("illegal_funct", 1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0), rtype(6'b111111), 0, 0, 0, '0);
    applyStimulus(mk("beq_first", 0, 2, 4'h6, 1, 0, 0, 1, 0, 0, 1, 0), itype(6'b000100), 0, 0, 1,
                  {6'b000100, 26'h3ff_0001});
    applyStimulus(mk("beq_second", 0, 2, 4'h6, 1, 0, 0, 1, 0, 0, 1, 0), {6'b000100, 26'h3ff_0001}, 0, 0, 0, '0);

    // LW aborted by reset in its second MEM cycle.
    exp_q.push_back(mk("lw_reset_abort", 3, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1));
    instr_valid      = 1'b1;
    Instruction_Code = itype(6'b100011);
    @(posedge clk); #1;
    instr_valid      = 1'b0;
    Instruction_Code = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(mk("add_after_reset", 0, 3, 4'h2, 1, 0, 1, 0, 0, 0, 1, 0), rtype(6'b100000), 0, 0, 0, '0);

    repeat (4) @(posedge clk);
    #1;
    while (exp_q.size() != 0) begin
      rec_t e;
      e = exp_q.pop_front();
      n_cmp++; n_bad++;
      $display("[TB] FAIL %s: no DUT event observed, required ev=%0d lat=%0d", e.name, e.ev, e.lat);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 32: instruction width.
REQ-002 SHALL have parameter OPC_W, default 6: opcode field width, bits [INSTR_W-1 -: OPC_W].
REQ-003 SHALL have parameter FUNCT_W, default 6: funct field width, bits [FUNCT_W-1:0].
REQ-004 SHALL have parameter ALU_OP_W, default 4: ALU_op width (min 4).
REQ-005 SHALL have parameter MEM_WAIT_MAX, default 15: maximum MEM-state wait cycles.
REQ-006 SHALL have the following ports, one per line:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- instr_valid  input  1  Instruction_Code valid
- Instruction_Code  input  INSTR_W  instruction
- instr_ready  output  1  block idle, can accept
- mem_ready  input  1  data memory completed access
- ALU_op  output  ALU_OP_W  registered ALU operation
- imm_signal  output  1  immediate operand select
- alu_en  output  1  ALU result capture strobe
- Reg_Write  output  1  register-file write strobe
- mem_read  output  1  data-memory read request
- mem_write  output  1  data-memory write request
- branch  output  1  BEQ evaluate strobe
- done  output  1  instruction retired pulse
- illegal_instr  output  1  undecodable-instruction pulse
- mem_error  output  1  memory-timeout pulse

Function
REQ-007 SHALL implement states IDLE, DECODE, EXECUTE, MEM, WB; encoding free.
REQ-008 SHALL assert instr_ready only in IDLE; on instr_valid&&instr_ready it SHALL latch Instruction_Code and go to DECODE.
REQ-009 Instruction_Code changes outside the acceptance edge SHALL NOT affect the in-flight instruction.
REQ-010 DECODE SHALL register ALU_op/imm_signal from the latched instruction and go to EXECUTE, or to IDLE with illegal_instr high one cycle if undecodable.
REQ-011 Opcode 0 (R-type) funct decode: 100000 add->0010, 100010 sub->0110, 100100 and->0000, 100101 or->0001, 000000 sll->1110, 000010 srl->1100; imm_signal=0; other funct illegal.
REQ-012 Opcode 111111 (ADDI), 100011 (LW), 101011 (SW): ALU_op=0010, imm_signal=1.
REQ-013 Opcode 000100 (BEQ): ALU_op=0110, imm_signal=0.
REQ-014 Any other opcode SHALL be illegal; illegal instructions SHALL never assert Reg_Write, mem_read, mem_write, branch or done.
REQ-015 EXECUTE SHALL assert alu_en for exactly one cycle, then: R-type/ADDI -> WB; LW/SW -> MEM; BEQ -> branch and done high that same cycle, then IDLE.
REQ-016 MEM SHALL hold mem_read (LW) or mem_write (SW) high every cycle until mem_ready sampled high; then LW -> WB, SW -> IDLE with done high in the mem_ready cycle.
REQ-017 MEM SHALL count wait cycles; if mem_ready still low after MEM_WAIT_MAX cycles in MEM, SHALL drop mem_read/mem_write, pulse mem_error one cycle, return to IDLE without done.
REQ-018 mem_ready outside MEM SHALL be ignored.
REQ-019 WB SHALL assert Reg_Write and done for exactly one cycle, then IDLE.
REQ-020 Latency after acceptance edge: R-type/ADDI Reg_Write in 3rd cycle; BEQ branch in 2nd; LW Reg_Write in 3rd cycle after mem_ready cycle's next edge (MEM min 1 cycle).
REQ-021 ALU_op/imm_signal SHALL hold their value from DECODE until the next DECODE.
REQ-022 Strobes (alu_en, Reg_Write, branch, done, illegal_instr, mem_error) SHALL be mutually consistent: at most one of done/illegal_instr/mem_error high per cycle.
REQ-023 Unused ALU_op bits above bit 3 SHALL be 0.

Reset
REQ-024 rst_n low at a rising edge SHALL force IDLE, ALU_op=0, all 1-bit outputs 0 except instr_ready=1 from the following cycle, wait counter=0.
REQ-025 Reset in any state, including mid-MEM, SHALL abort the instruction: no done, mem_read/mem_write low from the next cycle.

Verification
REQ-026 add (opc 0, funct 100000) accepted -> ALU_op=0010, imm_signal=0, alu_en cycle 2, Reg_Write+done cycle 3, instr_ready back cycle 4.
REQ-027 LW, mem_ready high on 3rd MEM cycle -> mem_read high exactly 3 cycles, imm_signal=1, Reg_Write+done next cycle.
REQ-028 SW, mem_ready never -> mem_write high 15 cycles, mem_error pulse, no done, return IDLE.
REQ-029 opcode 010101 and R-type funct 111111 -> illegal_instr pulse in DECODE, no strobes, instr_ready high next cycle.
REQ-030 rst_n low during MEM of LW -> mem_read low next cycle, no Reg_Write/done, IDLE with ALU_op=0.
REQ-031 BEQ back-to-back with instr_valid held high -> branch+done cycle 2, next instruction accepted at cycle 3 edge only.
